// File: rtl/rds_group_serializer.sv
// rds_group_serializer: fetches 8-byte groups from BRAM and emits 4x26-bit RDS blocks (info + checkword) per bit tick.
// Define RDS_DIFF_EN to differentially encode rds_bit; the default build sends the coded bits directly.
module rds_group_serializer #(
  parameter int ADDR_BITS = 9,
  parameter int MSG_BYTES = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 bit_tick,
  output logic [ADDR_BITS-1:0] imem_addr,
  input  logic [7:0]           imem_data_in,
  output logic                 rds_bit,
  output logic                 rds_bit_valid,
  output logic                 group_start,
  output logic                 busy
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  localparam logic [9:0]           POLY      = 10'h1B9;
  localparam logic [ADDR_BITS-1:0] LAST_BASE = ADDR_BITS'(MSG_BYTES - 8);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           fcnt_q, fcnt_d;
  logic [63:0]          buf_q, buf_d;
  logic [9:0]           crc_q, crc_d;
  logic [1:0]           blk_q, blk_d;
  logic [4:0]           pos_q, pos_d;
  logic                 pend_q, pend_d;
  logic                 bit_q, bit_d;
  logic                 vld_q, vld_d;
  logic                 gs_q, gs_d;
  logic                 busy_q, busy_d;
  logic                 coded, fb;
  logic [9:0]           offset;
  logic [3:0]           cw_idx;

  always_comb begin
    case (blk_q)
      2'd0:    offset = 10'h0FC;
      2'd1:    offset = 10'h198;
      2'd2:    offset = 10'h168;
      default: offset = 10'h1B4;
    endcase
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    buf_d   = buf_q;
    crc_d   = crc_q;
    blk_d   = blk_q;
    pos_d   = pos_q;
    pend_d  = pend_q;
    bit_d   = bit_q;
    vld_d   = 1'b0;
    gs_d    = 1'b0;
    coded   = 1'b0;
    fb      = 1'b0;
    cw_idx  = 4'(5'd25 - pos_q);
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_FETCH;
          addr_d  = base_q;
          fcnt_d  = 4'd0;
        end
      end
      S_FETCH: begin
        if (bit_tick) pend_d = 1'b1;
        if (fcnt_q < 4'd7) addr_d = addr_q + ADDR_BITS'(1);
        // Read data trails the address by one cycle, so byte n lands while fcnt == n+1.
        if (fcnt_q != 4'd0) buf_d = {buf_q[55:0], imem_data_in};
        fcnt_d = fcnt_q + 4'd1;
        if (fcnt_q == 4'd8) begin
          state_d = S_SEND;
          blk_d   = 2'd0;
          pos_d   = 5'd0;
          crc_d   = 10'd0;
        end
      end
      S_SEND: begin
        pend_d = 1'b0;
        if (bit_tick || pend_q) begin
          if (pos_q < 5'd16) begin
            coded = buf_q[63];
            fb    = coded ^ crc_q[9];
            crc_d = {crc_q[8:0], 1'b0} ^ (fb ? POLY : 10'h000);
            buf_d = {buf_q[62:0], 1'b0};
          end else begin
            // Checkword bits shift out of the CRC register itself, offset applied on the fly.
            coded = crc_q[9] ^ offset[cw_idx];
            crc_d = {crc_q[8:0], 1'b0};
          end
          vld_d = 1'b1;
          gs_d  = (blk_q == 2'd0) && (pos_q == 5'd0);
`ifdef RDS_DIFF_EN
          bit_d = coded ^ bit_q;
`else
          bit_d = coded;
`endif
          if (pos_q == 5'd25) begin
            pos_d = 5'd0;
            crc_d = 10'd0;
            blk_d = blk_q + 2'd1;
            if (blk_q == 2'd3) begin
              base_d = (base_q == LAST_BASE) ? '0 : base_q + ADDR_BITS'(8);
              if (en) begin
                state_d = S_FETCH;
                addr_d  = base_d;
                fcnt_d  = 4'd0;
              end else begin
                state_d = S_IDLE;
              end
            end
          end else begin
            pos_d = pos_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      fcnt_q  <= 4'd0;
      buf_q   <= 64'd0;
      crc_q   <= 10'd0;
      blk_q   <= 2'd0;
      pos_q   <= 5'd0;
      pend_q  <= 1'b0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      gs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      fcnt_q  <= fcnt_d;
      buf_q   <= buf_d;
      crc_q   <= crc_d;
      blk_q   <= blk_d;
      pos_q   <= pos_d;
      pend_q  <= pend_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      gs_q    <= gs_d;
      busy_q  <= busy_d;
    end
  end

  assign imem_addr     = addr_q;
  assign rds_bit       = bit_q;
  assign rds_bit_valid = vld_q;
  assign group_start   = gs_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_rds_group_serializer.sv
// Bench for rds_group_serializer: BRAM model, random bit ticks, and a group-level reference of the RDS stream.
`timescale 1ns/1ps
module tb_rds_group_serializer;
  localparam int ADDR_BITS = 9;
  localparam int MSG_BYTES = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic tick_gen = 1'b0;
  logic tick_force = 1'b0;
  logic bit_tick;
  logic [ADDR_BITS-1:0] imem_addr;
  logic [7:0] imem_data_in = 8'd0;
  logic rds_bit, rds_bit_valid, group_start, busy;

  logic [7:0] mem [0:511];
  logic [9:0] offs [0:3] = '{10'h0FC, 10'h198, 10'h168, 10'h1B4};
  bit exp_bits [0:103];
  bit got_q [$];
  bit raw_q [$];

  int checks = 0;
  int errors = 0;
  int bitnum = 0, groups_done = 0, valid_cnt = 0, gs_cnt = 0, exp_base = 0, busy_ticks = 0;
  logic exp_prev = 1'b0, raw_prev = 1'b0, tick_samp = 1'b0, chk_on = 1'b0;

  assign bit_tick = tick_gen | tick_force;

  rds_group_serializer #(.ADDR_BITS(ADDR_BITS), .MSG_BYTES(MSG_BYTES)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_tick(bit_tick), .imem_addr(imem_addr),
    .imem_data_in(imem_data_in), .rds_bit(rds_bit), .rds_bit_valid(rds_bit_valid),
    .group_start(group_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkn(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Remainder of m(x)*x^10 divided by x^10+x^8+x^7+x^5+x^4+x^3+1.
  function automatic logic [9:0] ref_crc(input logic [15:0] m);
    logic [25:0] v;
    v = {m, 10'd0};
    for (int i = 25; i >= 10; i--)
      if (v[i]) v = v ^ (26'h5B9 << (i - 10));
    return v[9:0];
  endfunction

  task automatic build(input int b);
    logic [15:0] info;
    logic [9:0] cw;
    for (int k = 0; k < 4; k++) begin
      info = {mem[b + 2 * k], mem[b + 2 * k + 1]};
      cw = ref_crc(info) ^ offs[k];
      for (int j = 0; j < 16; j++) exp_bits[k * 26 + j] = info[15 - j];
      for (int j = 0; j < 10; j++) exp_bits[k * 26 + 16 + j] = cw[9 - j];
    end
  endtask

  function automatic logic [15:0] get_bits(input int s, input int n);
    logic [15:0] r;
    r = 16'd0;
    for (int j = 0; j < n; j++) r = {r[14:0], logic'(got_q[s + j])};
    return r;
  endfunction

  // BRAM: data for the address seen at one edge is presented for the following cycle.
  always @(posedge clk) begin : bram
    logic [ADDR_BITS-1:0] a;
    a = imem_addr;
    #1 imem_data_in = mem[a];
  end

  initial begin : ticker
    forever begin
      repeat ($urandom_range(11, 24)) @(posedge clk);
      #1 tick_gen = 1'b1;
      @(posedge clk);
      #1 tick_gen = 1'b0;
    end
  end

  always @(posedge clk) begin
    tick_samp = bit_tick;
    if (rst) busy_ticks = 0;
    else if (bit_tick && busy) busy_ticks++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (rds_bit_valid) begin
        logic e;
        if (bitnum == 0) build(exp_base);
        e = exp_bits[bitnum];
`ifdef RDS_DIFF_EN
        e = e ^ exp_prev;
        got_q.push_back(rds_bit ^ raw_prev);
`else
        got_q.push_back(rds_bit);
`endif
        raw_q.push_back(rds_bit);
        chk1("rds_bit", rds_bit, e);
        chk1("group_start", group_start, logic'(bitnum == 0));
        if (bitnum != 0) chk1("valid_follows_tick", tick_samp, 1'b1);
        raw_prev = rds_bit;
        exp_prev = e;
        valid_cnt++;
        if (group_start) gs_cnt++;
        bitnum++;
        if (bitnum == 104) begin
          bitnum = 0;
          groups_done++;
          exp_base = (exp_base + 8) % MSG_BYTES;
        end
      end else begin
        chk1("rds_bit_hold", rds_bit, exp_prev);
        chk1("group_start_quiet", group_start, 1'b0);
      end
    end
    if (rst) begin
      bitnum = 0;
      exp_base = 0;
      exp_prev = 1'b0;
      raw_prev = 1'b0;
      valid_cnt = 0;
    end
  end

  task automatic wait_pos(input int g, input int b, input int limit, input string nm);
    int n;
    n = 0;
    while (!(groups_done == g && bitnum == b) && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (n >= limit) begin
      errors++;
      checks++;
      $display("FAIL %s: timeout waiting for group %0d bit %0d (at group %0d bit %0d)", nm, g, b, groups_done, bitnum);
    end
  endtask

  task automatic check_fetch_addrs(input int b, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1({nm, "_busy"}, busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chkn({nm, "_addr"}, 32'(imem_addr), 32'(b + i));
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk1({nm, "_rds_bit"}, rds_bit, 1'b0);
    chk1({nm, "_valid"}, rds_bit_valid, 1'b0);
    chk1({nm, "_group_start"}, group_start, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b0);
    chkn({nm, "_addr"}, 32'(imem_addr), 32'd0);
  endtask

  initial begin : main
    int g, a, v;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    mem[11] = 8'h01;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    chk_on = 1'b1;

    // Four groups: zero group, B info 0x0001, random group, wrap back to base 0.
    en = 1'b1;
    got_q.delete();
    raw_q.delete();
    check_fetch_addrs(0, "first_fetch");
    wait_pos(4, 0, 12000, "four_groups");
    chkn("zero_A_cw", 32'(get_bits(16, 10)), 32'h0FC);
    chkn("zero_B_cw", 32'(get_bits(42, 10)), 32'h198);
    chkn("zero_C_cw", 32'(get_bits(68, 10)), 32'h168);
    chkn("zero_D_cw", 32'(get_bits(94, 10)), 32'h1B4);
    chkn("g1_B_info", 32'(get_bits(130, 16)), 32'h0001);
    chkn("g1_B_cw", 32'(get_bits(146, 10)), 32'h021);
    chkn("group_start_count", 32'(gs_cnt), 32'd4);
`ifdef RDS_DIFF_EN
    chk1("diff_before_first_one", logic'(raw_q[17]), 1'b0);
    chk1("diff_first_one", logic'(raw_q[18]), 1'b1);
`endif

    // Drop en mid-group: the rest of the group still goes out, then the block idles.
    g = groups_done;
    wait_pos(g, 50, 3000, "reach_bit50");
    #1 en = 1'b0;
    wait_pos(g + 1, 0, 3000, "finish_after_en_drop");
    repeat (5) @(negedge clk);
    chk1("idle_after_drop", busy, 1'b0);
    chkn("ticks_vs_bits", 32'(busy_ticks), 32'(valid_cnt));
    a = int'(imem_addr);
    v = valid_cnt;
    repeat (300) @(negedge clk);
    chkn("no_bits_when_idle", 32'(valid_cnt), 32'(v));
    chkn("no_reads_when_idle", 32'(imem_addr), 32'(a));
    chk1("still_idle", busy, 1'b0);

    // Random contents, then reset in the middle of the third group.
    for (int i = 0; i < MSG_BYTES; i++) mem[i] = 8'($urandom);
    en = 1'b1;
    check_fetch_addrs(exp_base, "resume_fetch");
    g = groups_done;
    wait_pos(g + 2, 30, 8000, "reach_g2_bit30");
    #1;
    rst = 1'b1;
    tick_force = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick_force = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    repeat (30) @(negedge clk);
    chk1("idle_ignores_ticks", busy, 1'b0);

    en = 1'b1;
    check_fetch_addrs(0, "post_reset_fetch");
    en = 1'b0;
    g = groups_done;
    wait_pos(g + 1, 0, 3000, "post_reset_group");
    repeat (5) @(negedge clk);
    chk1("final_idle", busy, 1'b0);
    chkn("final_ticks_vs_bits", 32'(busy_ticks), 32'(valid_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
